dram_stream_reader: RTL and testbench
=====================================

// Module: dram_stream_reader
// PURPOSE
//  Parametrised DDR-to-stream read engine: fetches LENGTH samples from DDR (Avalon-MM master, BASE, +STEP),
//  buffers them in a prefetch FIFO and emits one sample every RATE clocks on a streaming port.
//  Adds over the prior engine: waitrequest-correct pipelined reads, bounded outstanding reads,
//  loop mode, abort, restart without reset, and underrun/emitted counters. Configured by a CSR slave.
// PARAMETERS
//  DATA_W      16  sample width (ddr_readdata, d_out)
//  ADDR_W      32  DDR address width
//  FIFO_DEPTH  16  prefetch FIFO entries; power of 2, >=2
// PORTS
//  clk              in   1       sole clock
//  rst_n            in   1       asynchronous, active-low reset
//  ddr_addr         out  ADDR_W  read address
//  ddr_read         out  1       read request
//  ddr_waitrequest  in   1       slave stall
//  ddr_readdata     in   DATA_W  read data
//  ddr_readdatavalid in  1       read data valid
//  addr             in   3       CSR word address
//  writedata        in   32      CSR write data
//  write            in   1       CSR write strobe
//  read             in   1       CSR read strobe
//  readdata         out  32      CSR read data, valid 1 cycle after read
//  d_out            out  DATA_W  streamed sample
//  vout             out  1       1-cycle pulse, d_out valid
//  d_clk            out  1       toggles on every emitted sample
// BEHAVIOUR
//  Reset: all outputs 0; base=0, length=0, step=1, rate=1, loop=0, counters 0, state IDLE, FIFO empty.
//  CSR map (W=write, R=read): 0 base RW; 1 length (samples) RW; 2 step RW; 3 rate (clks/sample, 0 treated as 1) RW;
//   4 control W: b0 start, b1 loop, b2 abort (loop bit latched on every write to 4); 5 status R: b0 done, b1 busy, b2 loop;
//   6 underrun count R, any W clears; 7 emitted-sample count R (cleared on start). Unmapped reads -> 32'hdeadbeef.
//  base/length/step/rate are shadowed at start; CSR writes during a run affect only the next start.
//  States: IDLE -> (start) RUN; RUN -> (all issued, loop=0) DRAIN; DRAIN -> (pending=0, FIFO empty) DONE;
//   DONE -> (start) RUN; any non-IDLE -> (abort) FLUSH; FLUSH -> (pending=0) IDLE, FIFO cleared, done=0.
//  start with length=0 -> DONE next cycle, no DDR traffic. start while RUN/DRAIN/FLUSH ignored. abort beats start same cycle.
//  Avalon: ddr_read/ddr_addr held stable while ddr_waitrequest=1; request accepted on ddr_read & !ddr_waitrequest.
//   New request only if issued<length and (fifo_count + pending) < FIFO_DEPTH (FIFO can never overflow).
//   Accepted: ddr_addr += step (ADDR_W wrap), issued++. pending +1 on accept, -1 on readdatavalid, unchanged if both.
//   readdatavalid pushes ddr_readdata into FIFO in every state; in FLUSH data is discarded.
//  Loop mode: when issued reaches length, ddr_addr<=base, issued<=0; run continues until abort.
//  Rate tick: counter 1..rate, runs in RUN/DRAIN; first tick rate cycles after entering RUN.
//   On tick with FIFO non-empty: pop, d_out<=data, vout=1 for 1 cycle, d_clk toggles, emitted++.
//   On tick with FIFO empty (RUN only): underrun++ (saturates at 2^32-1), d_out holds, vout=0.
//  done=1 only in DONE; busy=1 in RUN/DRAIN/FLUSH. d_out holds last sample after completion; d_clk returns to 0 in IDLE.
// TESTING
//  base=0x100,len=4,step=2,rate=3,no stall -> ddr_addr 0x100,0x102,0x104,0x106; 4 vout pulses 3 clks apart; done=1, emitted=4.
//  As above, waitrequest high 5 clks on 2nd request -> ddr_addr/read held 5 clks; no duplicate or lost read; output order intact.
//  FIFO_DEPTH=4, readdatavalid delayed 20 clks -> never >4 outstanding+buffered; underrun>0 at CSR6; write CSR6 -> reads 0.
//  len=3, loop=1 -> addresses repeat base..base+2*step; after abort: FLUSH, pending drains, status=0, FIFO empty.
//  rst_n low mid-RUN with 2 reads pending -> all outputs 0 immediately; late readdatavalid after release ignored (IDLE, FIFO empty).
//  len=0 start -> done next cycle, ddr_read never asserted; second start from DONE reruns with new shadowed length.

Source files
------------

// File: rtl/dram_stream_reader_if.sv
// Bus bundle for dram_stream_reader: Avalon-MM read master, CSR slave and sample stream.
// master = the reader engine, slave = the surrounding system (DDR, CSR host, stream sink).
interface dram_stream_reader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] ddr_addr;
  logic              ddr_read;
  logic              ddr_waitrequest;
  logic [DATA_W-1:0] ddr_readdata;
  logic              ddr_readdatavalid;

  logic [2:0]        addr;
  logic [31:0]       writedata;
  logic              write;
  logic              read;
  logic [31:0]       readdata;

  logic [DATA_W-1:0] d_out;
  logic              vout;
  logic              d_clk;

  modport master (
    output ddr_addr, ddr_read,
    input  ddr_waitrequest, ddr_readdata, ddr_readdatavalid,
    input  addr, writedata, write, read,
    output readdata,
    output d_out, vout, d_clk
  );

  modport slave (
    input  ddr_addr, ddr_read,
    output ddr_waitrequest, ddr_readdata, ddr_readdatavalid,
    output addr, writedata, write, read,
    input  readdata,
    input  d_out, vout, d_clk
  );
endinterface

// File: rtl/dram_stream_reader.sv
// DDR-to-stream read engine: pipelined Avalon reads into a prefetch FIFO, one sample out
// every RATE clocks, with loop/abort/restart and CSR-visible underrun/emitted counters.
module dram_stream_reader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  dram_stream_reader_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, FLUSH} state_t;
  state_t state, state_nxt;

  logic [31:0] base_r, len_r, step_r, rate_r;
  logic        loop_r;
  logic [31:0] sh_base, sh_len, sh_step, sh_rate;
  logic [31:0] issued, issued_inc, rate_cnt, eff_rate;
  logic [31:0] underrun, emitted, csr_rd, readdata_q;

  logic [ADDR_W-1:0] ddr_addr_q;
  logic              ddr_read_q;
  logic [DATA_W-1:0] d_out_q;
  logic              vout_q, d_clk_q;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt, pending;
  logic [CW:0]       occ;

  logic ctrl_wr, start_req, abort_req, start_go;
  logic accept, ret, push, pop, tick, active, fifo_empty, more, req_nxt;
  logic done, busy;

  assign ctrl_wr   = bus.write && bus.addr == 3'd4;
  assign start_req = ctrl_wr && bus.writedata[0];
  assign abort_req = ctrl_wr && bus.writedata[2];
  assign start_go  = start_req && !abort_req && (state == IDLE || state == DONE);

  assign accept     = ddr_read_q && !bus.ddr_waitrequest;
  // Stray readdatavalid with nothing outstanding (e.g. after reset) is ignored.
  assign ret        = bus.ddr_readdatavalid && pending != '0;
  assign push       = ret && state != FLUSH;
  assign fifo_empty = fifo_cnt == '0;
  assign active     = state == RUN || state == DRAIN;
  assign eff_rate   = (sh_rate == 32'd0) ? 32'd1 : sh_rate;
  assign tick       = active && rate_cnt >= eff_rate;
  assign pop        = tick && !fifo_empty;
  assign issued_inc = issued + 32'(accept);
  assign done       = state == DONE;
  assign busy       = state == RUN || state == DRAIN || state == FLUSH;

  // Budget counts the request being accepted now; pops only ever loosen it.
  assign occ     = {1'b0, fifo_cnt} + {1'b0, pending} + {{CW{1'b0}}, accept};
  assign more    = loop_r || issued_inc < sh_len;
  assign req_nxt = state == RUN && state_nxt == RUN && more && occ < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    state_nxt = state;
    if (abort_req && state != IDLE) state_nxt = FLUSH;
    else begin
      case (state)
        IDLE, DONE: if (start_go) state_nxt = (len_r == 32'd0) ? DONE : RUN;
        RUN:        if (!loop_r && issued >= sh_len) state_nxt = DRAIN;
        DRAIN:      if (pending == '0 && fifo_empty) state_nxt = DONE;
        // A request stalled at abort time must still complete before going idle.
        FLUSH:      if (pending == '0 && !ddr_read_q) state_nxt = IDLE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    csr_rd = 32'hdeadbeef;
    case (bus.addr)
      3'd0: csr_rd = base_r;
      3'd1: csr_rd = len_r;
      3'd2: csr_rd = step_r;
      3'd3: csr_rd = rate_r;
      3'd5: csr_rd = {29'd0, loop_r, busy, done};
      3'd6: csr_rd = underrun;
      3'd7: csr_rd = emitted;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base_r     <= '0;
      len_r      <= '0;
      step_r     <= 32'd1;
      rate_r     <= 32'd1;
      loop_r     <= 1'b0;
      sh_base    <= '0;
      sh_len     <= '0;
      sh_step    <= 32'd1;
      sh_rate    <= 32'd1;
      issued     <= '0;
      rate_cnt   <= 32'd1;
      underrun   <= '0;
      emitted    <= '0;
      readdata_q <= '0;
      ddr_addr_q <= '0;
      ddr_read_q <= 1'b0;
      d_out_q    <= '0;
      vout_q     <= 1'b0;
      d_clk_q    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      pending    <= '0;
    end else begin
      state <= state_nxt;

      if (bus.write) begin
        case (bus.addr)
          3'd0: base_r <= bus.writedata;
          3'd1: len_r  <= bus.writedata;
          3'd2: step_r <= bus.writedata;
          3'd3: rate_r <= bus.writedata;
          3'd4: loop_r <= bus.writedata[1];
          default: ;
        endcase
      end
      if (bus.read) readdata_q <= csr_rd;

      if (start_go) begin
        sh_base    <= base_r;
        sh_len     <= len_r;
        sh_step    <= step_r;
        sh_rate    <= rate_r;
        issued     <= '0;
        emitted    <= '0;
        ddr_addr_q <= ADDR_W'(base_r);
      end else if (accept && state == RUN) begin
        if (loop_r && issued_inc >= sh_len) begin
          ddr_addr_q <= ADDR_W'(sh_base);
          issued     <= '0;
        end else begin
          ddr_addr_q <= ddr_addr_q + ADDR_W'(sh_step);
          issued     <= issued_inc;
        end
      end
      ddr_read_q <= (ddr_read_q && bus.ddr_waitrequest) || req_nxt || (start_go && len_r != 32'd0);

      case ({accept, ret})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: ;
      endcase

      if (start_go || tick) rate_cnt <= 32'd1;
      else if (active)      rate_cnt <= rate_cnt + 32'd1;

      vout_q <= pop;
      if (pop) begin
        d_out_q <= mem[rd_ptr];
        d_clk_q <= ~d_clk_q;
        emitted <= emitted + 32'd1;
      end else if (state == IDLE) begin
        d_clk_q <= 1'b0;
      end

      if (tick && fifo_empty && state == RUN && underrun != '1) underrun <= underrun + 32'd1;
      if (bus.write && bus.addr == 3'd6) underrun <= '0;

      if (state == FLUSH) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
          2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.ddr_readdata;
  end

  assign bus.ddr_addr = ddr_addr_q;
  assign bus.ddr_read = ddr_read_q;
  assign bus.readdata = readdata_q;
  assign bus.d_out    = d_out_q;
  assign bus.vout     = vout_q;
  assign bus.d_clk    = d_clk_q;
endmodule

// File: tb/tb_dram_stream_reader.sv
// Directed bench for dram_stream_reader: CSR vector table plus hand-written run sequences
// against a latency/stall-programmable DDR responder.
module tb_dram_stream_reader;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_stream_reader_if #(.DATA_W(16), .ADDR_W(32)) bus ();
  dram_stream_reader #(.DATA_W(16), .ADDR_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct { logic [31:0] a; int due; } rsp_t;
  typedef struct { logic [2:0] wa; bit wr; logic [31:0] wd; logic [2:0] ra; logic [31:0] exp; } vec_t;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, lat = 1;
  int acc_total = 0, ret_total = 0, emit_total = 0, rd_cycles = 0;
  int stall_idx = -1, stall_left = 0, hold_err = 0, dclk_err = 0, max_infl = 0;
  bit stall_on = 0, track = 0;
  logic dclk_prev = 1'b0;
  logic [31:0] stall_addr = '0;
  logic [31:0] acc_q[$];
  logic [15:0] out_q[$];
  int pcyc_q[$];
  rsp_t rq[$];

  function automatic logic [15:0] fdat(input logic [31:0] a);
    return a[15:0] ^ 16'ha5c3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); bus.addr = a; bus.writedata = d; bus.write = 1'b1;
    @(negedge clk); bus.write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk); bus.addr = a; bus.read = 1'b1;
    @(negedge clk); bus.read = 1'b0; d = bus.readdata;
  endtask

  task automatic wait_status(input logic [31:0] mask, input logic [31:0] val, input int max_rd, input string nm);
    logic [31:0] s;
    int n = 0;
    do begin csr_rd(3'd5, s); n++; end while ((s & mask) != val && n < max_rd);
    chk(nm, s & mask, val);
  endtask

  task automatic config_run(input logic [31:0] b, input logic [31:0] l, input logic [31:0] s, input logic [31:0] r);
    csr_wr(3'd0, b); csr_wr(3'd1, l); csr_wr(3'd2, s); csr_wr(3'd3, r);
  endtask

  // DDR responder and stream monitor; all sampling and driving on the falling edge.
  initial begin
    bus.ddr_waitrequest = 1'b0; bus.ddr_readdatavalid = 1'b0; bus.ddr_readdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.vout) begin
        out_q.push_back(bus.d_out); pcyc_q.push_back(cyc); emit_total++;
        if (bus.d_clk == dclk_prev) dclk_err++;
      end
      dclk_prev = bus.d_clk;
      if (bus.ddr_read) rd_cycles++;
      if (stall_left > 0 && acc_total == stall_idx) begin
        if (!bus.ddr_read) begin
          if (stall_on) hold_err++;
          bus.ddr_waitrequest = 1'b0;
        end else begin
          stall_on = 1;
          if (bus.ddr_addr != stall_addr) hold_err++;
          bus.ddr_waitrequest = 1'b1;
          stall_left--;
        end
      end else bus.ddr_waitrequest = 1'b0;
      if (bus.ddr_read && !bus.ddr_waitrequest) begin
        acc_q.push_back(bus.ddr_addr);
        rq.push_back('{bus.ddr_addr, cyc + lat});
        acc_total++;
      end
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        bus.ddr_readdatavalid = 1'b1; bus.ddr_readdata = fdat(rq[0].a);
        rq.delete(0); ret_total++;
      end else bus.ddr_readdatavalid = 1'b0;
      if (track && acc_total - emit_total > max_infl) max_infl = acc_total - emit_total;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[16];
    logic [31:0] r;
    int o0, a0, n, e0, r0;

    bus.addr = '0; bus.writedata = '0; bus.write = 1'b0; bus.read = 1'b0;
    vt[0]  = '{3'd0, 1'b0, 32'h0,        3'd0, 32'h0};
    vt[1]  = '{3'd0, 1'b0, 32'h0,        3'd1, 32'h0};
    vt[2]  = '{3'd0, 1'b0, 32'h0,        3'd2, 32'h1};
    vt[3]  = '{3'd0, 1'b0, 32'h0,        3'd3, 32'h1};
    vt[4]  = '{3'd0, 1'b0, 32'h0,        3'd4, 32'hdeadbeef};
    vt[5]  = '{3'd0, 1'b0, 32'h0,        3'd5, 32'h0};
    vt[6]  = '{3'd0, 1'b0, 32'h0,        3'd6, 32'h0};
    vt[7]  = '{3'd0, 1'b0, 32'h0,        3'd7, 32'h0};
    vt[8]  = '{3'd0, 1'b1, 32'h12345678, 3'd0, 32'h12345678};
    vt[9]  = '{3'd1, 1'b1, 32'h7,        3'd1, 32'h7};
    vt[10] = '{3'd2, 1'b1, 32'hfffffffe, 3'd2, 32'hfffffffe};
    vt[11] = '{3'd3, 1'b1, 32'h0,        3'd3, 32'h0};
    vt[12] = '{3'd6, 1'b1, 32'hffffffff, 3'd6, 32'h0};
    vt[13] = '{3'd5, 1'b1, 32'hff,       3'd5, 32'h0};
    vt[14] = '{3'd4, 1'b1, 32'h2,        3'd5, 32'h4};
    vt[15] = '{3'd4, 1'b1, 32'h0,        3'd5, 32'h0};

    #1;
    chk("rst_outputs", {29'd0, bus.ddr_read, bus.vout, bus.d_clk}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) csr_wr(vt[i].wa, vt[i].wd);
      csr_rd(vt[i].ra, r);
      chk($sformatf("csr_vec%0d", i), r, vt[i].exp);
    end

    // Basic run, no stall.
    lat = 1;
    config_run(32'h100, 32'd4, 32'd2, 32'd3);
    o0 = out_q.size(); a0 = acc_q.size();
    csr_wr(3'd4, 32'h1);
    wait_status(32'h3, 32'h1, 100, "t1_done");
    chk("t1_npulse", out_q.size() - o0, 4);
    chk("t1_nacc", acc_q.size() - a0, 4);
    for (int i = 0; i < 4; i++) begin
      if (a0 + i < acc_q.size()) chk($sformatf("t1_addr%0d", i), acc_q[a0+i], 32'h100 + 32'(2*i));
      if (o0 + i < out_q.size()) chk($sformatf("t1_data%0d", i), 32'(out_q[o0+i]), 32'(fdat(32'h100 + 32'(2*i))));
      if (i > 0 && o0 + i < pcyc_q.size()) chk($sformatf("t1_gap%0d", i), pcyc_q[o0+i] - pcyc_q[o0+i-1], 3);
    end
    csr_rd(3'd7, r); chk("t1_emitted", r, 32'd4);

    // Restart from DONE with a 5-cycle stall on the second request.
    o0 = out_q.size(); a0 = acc_q.size();
    stall_idx = acc_total + 1; stall_left = 5; stall_addr = 32'h102; stall_on = 0;
    csr_wr(3'd4, 32'h1);
    wait_status(32'h3, 32'h1, 100, "t2_done");
    chk("t2_stall_seen", stall_left, 0);
    chk("t2_hold", hold_err, 0);
    chk("t2_nacc", acc_q.size() - a0, 4);
    chk("t2_npulse", out_q.size() - o0, 4);
    for (int i = 0; i < 4; i++) begin
      if (a0 + i < acc_q.size()) chk($sformatf("t2_addr%0d", i), acc_q[a0+i], 32'h100 + 32'(2*i));
      if (o0 + i < out_q.size()) chk($sformatf("t2_data%0d", i), 32'(out_q[o0+i]), 32'(fdat(32'h100 + 32'(2*i))));
    end
    csr_rd(3'd7, r); chk("t2_emitted", r, 32'd4);

    // Slow memory: outstanding+buffered bounded by FIFO depth, underruns counted.
    lat = 20;
    config_run(32'h0, 32'd8, 32'd1, 32'd1);
    o0 = out_q.size(); max_infl = 0; track = 1;
    csr_wr(3'd4, 32'h1);
    wait_status(32'h3, 32'h1, 200, "t3_done");
    track = 0;
    chk("t3_max_inflight", max_infl, DEPTH);
    chk("t3_npulse", out_q.size() - o0, 8);
    for (int i = 0; i < 8; i++)
      if (o0 + i < out_q.size()) chk($sformatf("t3_data%0d", i), 32'(out_q[o0+i]), 32'(fdat(32'(i))));
    csr_rd(3'd6, r); chk("t3_underrun_nz", 32'(r != 0), 32'd1);
    csr_wr(3'd6, 32'h0);
    csr_rd(3'd6, r); chk("t3_underrun_clr", r, 32'd0);

    // Loop mode, then abort.
    lat = 1;
    config_run(32'h200, 32'd3, 32'd2, 32'd1);
    a0 = acc_q.size();
    csr_wr(3'd4, 32'h3);
    n = 0;
    while (acc_q.size() - a0 < 7 && n < 200) begin @(negedge clk); n++; end
    csr_rd(3'd5, r); chk("t4_status_loop", r, 32'h6);
    csr_wr(3'd4, 32'h4);
    wait_status(32'h7, 32'h0, 50, "t4_idle");
    chk("t4_outstanding", acc_total - ret_total, 0);
    for (int i = 0; i < 7; i++)
      if (a0 + i < acc_q.size()) chk($sformatf("t4_addr%0d", i), acc_q[a0+i], 32'h200 + 32'(2*(i%3)));
    config_run(32'h300, 32'd1, 32'd1, 32'd1);
    o0 = out_q.size();
    csr_wr(3'd4, 32'h1);
    wait_status(32'h3, 32'h1, 50, "t4_rerun_done");
    chk("t4_rerun_npulse", out_q.size() - o0, 1);
    if (o0 < out_q.size()) chk("t4_rerun_data", 32'(out_q[o0]), 32'(fdat(32'h300)));

    // Reset mid-run with two reads outstanding.
    lat = 20;
    config_run(32'h600, 32'd4, 32'd1, 32'd100);
    csr_wr(3'd4, 32'h1);
    n = 0;
    while (acc_total - ret_total < 2 && n < 100) begin @(posedge clk); n++; end
    chk("t5_two_pending", acc_total - ret_total, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_ctl", {29'd0, bus.ddr_read, bus.vout, bus.d_clk}, 32'h0);
    chk("t5_rst_addr", bus.ddr_addr, 32'h0);
    chk("t5_rst_dout", 32'(bus.d_out), 32'h0);
    chk("t5_rst_readdata", bus.readdata, 32'h0);
    e0 = emit_total;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("t5_late_returned", acc_total - ret_total, 0);
    chk("t5_no_pulse", emit_total - e0, 0);
    csr_rd(3'd5, r); chk("t5_status", r, 32'h0);
    lat = 1;
    config_run(32'h500, 32'd1, 32'd1, 32'd1);
    o0 = out_q.size();
    csr_wr(3'd4, 32'h1);
    wait_status(32'h3, 32'h1, 50, "t5_rerun_done");
    chk("t5_rerun_npulse", out_q.size() - o0, 1);
    if (o0 < out_q.size()) chk("t5_rerun_data", 32'(out_q[o0]), 32'(fdat(32'h500)));

    // Zero length, then restart from DONE with new length and rate 0.
    csr_wr(3'd1, 32'd0);
    r0 = rd_cycles;
    csr_wr(3'd4, 32'h1);
    csr_rd(3'd5, r); chk("t6_len0_done", r, 32'h1);
    config_run(32'h400, 32'd2, 32'd2, 32'd0);
    chk("t6_no_read", rd_cycles - r0, 0);
    o0 = out_q.size();
    csr_wr(3'd4, 32'h1);
    wait_status(32'h3, 32'h1, 50, "t6_rerun_done");
    csr_rd(3'd7, r); chk("t6_emitted", r, 32'd2);
    for (int i = 0; i < 2; i++)
      if (o0 + i < out_q.size()) chk($sformatf("t6_data%0d", i), 32'(out_q[o0+i]), 32'(fdat(32'h400 + 32'(2*i))));
    chk("d_clk_toggle", dclk_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
